if_stage: RTL and testbench

//  Instruction-fetch stage of Pipelined_CPU: owns the PC register and the IF/ID pipeline register.

---
 rtl/if_stage.sv | 152 +++++++++++++++
 tb/tb_if_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, stall/redirect handling, fetch halt.
// Optional performance counters enabled by defining IF_PERF_CNT_EN.
//
//  state      | meaning
//  BOOT       | first edge after reset, PC held, IF/ID bubble
//  RUN        | normal sequential fetch
//  REDIR_PEND | redirect arrived during stall, target buffered until stall drops
//  HALT       | PC ran past end of instruction memory, IF/ID bubbles
module if_stage #(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  IMEM_DEPTH = 256,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [31:0]         ifid_instr,
  output logic [PC_WIDTH-1:0] ifid_pc_plus4,
  output logic                ifid_valid,
  output logic                halted,
  output logic [31:0]         fetch_count,
  output logic [31:0]         stall_count
);

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    REDIR_PEND = 2'd2,
    HALT       = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_LIMIT = PC_WIDTH'(IMEM_DEPTH * 4);

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic [PC_WIDTH-1:0] pend, pend_nxt;
  logic [31:0]         instr_nxt;
  logic [PC_WIDTH-1:0] pp4_nxt;
  logic                valid_nxt;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] tgt_aligned;

  assign pc_plus4    = pc + PC_WIDTH'(4);
  assign tgt_aligned = redirect_target & ~(PC_WIDTH'(3));
  assign imem_addr   = pc;
  assign pc_out      = pc;
  assign halted      = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      pend          <= '0;
      ifid_instr    <= '0;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      pend          <= pend_nxt;
      ifid_instr    <= instr_nxt;
      ifid_pc_plus4 <= pp4_nxt;
      ifid_valid    <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend;
    instr_nxt = ifid_instr;
    pp4_nxt   = ifid_pc_plus4;
    valid_nxt = ifid_valid;
    case (state)
      BOOT: begin
        instr_nxt = '0;
        pp4_nxt   = '0;
        valid_nxt = 1'b0;
        state_nxt = RUN;
      end
      RUN, HALT: begin
        if (redirect_valid && !stall) begin
          pc_nxt    = tgt_aligned;
          instr_nxt = '0;
          pp4_nxt   = '0;
          valid_nxt = 1'b0;
          state_nxt = RUN;
        end else if (redirect_valid) begin
          pend_nxt  = tgt_aligned;
          state_nxt = REDIR_PEND;
        end else if (stall) begin
          state_nxt = state;
        end else if (state == RUN) begin
          instr_nxt = imem_rdata;
          pp4_nxt   = pc_plus4;
          valid_nxt = 1'b1;
          pc_nxt    = pc_plus4;
          if (pc_plus4 >= PC_LIMIT) state_nxt = HALT;
        end else begin
          // halted with no redirect: keep feeding bubbles, ignore imem
          instr_nxt = '0;
          pp4_nxt   = '0;
          valid_nxt = 1'b0;
        end
      end
      REDIR_PEND: begin
        if (stall) begin
          if (redirect_valid) pend_nxt = tgt_aligned;
        end else begin
          pc_nxt    = redirect_valid ? tgt_aligned : pend;
          instr_nxt = '0;
          pp4_nxt   = '0;
          valid_nxt = 1'b0;
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

`ifdef IF_PERF_CNT_EN
  logic        fetch_en;
  logic        stall_en;
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  assign fetch_en = (state == RUN) && !stall && !redirect_valid;
  assign stall_en = stall && (state != BOOT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fetch_en && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_en && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign fetch_count = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed scenarios then random stall/redirect/reset traffic,
// checked against a flag-based behavioural model of the fetch stage.
module tb_if_stage;
  localparam int          DEPTH  = 64;
  localparam logic [31:0] LIMIT  = 32'(DEPTH * 4);
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] imem_addr, imem_rdata, pc_out, ifid_instr, ifid_pc_plus4;
  logic [31:0] fetch_count, stall_count;
  logic        ifid_valid, halted;
  logic [31:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        valid;
    logic        halted;
    logic [31:0] fc;
    logic [31:0] sc;
  } exp_t;
  exp_t q[$];

  // behavioural model state
  logic [31:0] m_pc, m_instr, m_pp4, m_pend;
  logic        m_valid, m_halted, m_pend_flag, m_boot;
  longint      m_fc, m_sc;

  if_stage #(.PC_WIDTH(32), .IMEM_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid), .halted(halted), .fetch_count(fetch_count),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr < LIMIT) ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a < LIMIT) return mem[a[7:2]];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void bubble();
    m_instr = '0;
    m_pp4   = '0;
    m_valid = 1'b0;
  endfunction

  // one clock of stimulus: drive inputs at negedge, advance model, queue expected post-edge outputs
  task automatic step(input bit rst, input bit st, input bit rv, input logic [31:0] tgt);
    logic [31:0] al;
    exp_t e;
    @(negedge clk);
    rst_n = !rst;
    stall = st;
    redirect_valid = rv;
    redirect_target = tgt;
    al = {tgt[31:2], 2'b00};
    if (rst) begin
      m_pc = RST_PC; bubble(); m_halted = 0; m_pend_flag = 0; m_pend = 0;
      m_boot = 1; m_fc = 0; m_sc = 0;
    end else if (m_boot) begin
      m_boot = 0; bubble();
    end else begin
      if (st && m_sc < 64'hFFFF_FFFF) m_sc++;
      if (m_pend_flag) begin
        if (st) begin
          if (rv) m_pend = al;
        end else begin
          m_pc = rv ? al : m_pend; bubble(); m_pend_flag = 0;
        end
      end else if (rv && !st) begin
        m_pc = al; bubble(); m_halted = 0;
      end else if (rv) begin
        m_pend = al; m_pend_flag = 1; m_halted = 0;
      end else if (st) begin
        m_halted = m_halted;
      end else if (m_halted) begin
        bubble();
      end else begin
        m_instr = word_at(m_pc);
        m_pp4   = m_pc + 32'd4;
        m_valid = 1;
        m_pc    = m_pc + 32'd4;
        if (m_fc < 64'hFFFF_FFFF) m_fc++;
        if (m_pc >= LIMIT) m_halted = 1;
      end
    end
    e.pc = m_pc; e.instr = m_instr; e.pp4 = m_pp4; e.valid = m_valid; e.halted = m_halted;
`ifdef IF_PERF_CNT_EN
    e.fc = m_fc[31:0]; e.sc = m_sc[31:0];
`else
    e.fc = 32'd0; e.sc = 32'd0;
`endif
    q.push_back(e);
  endtask

  // monitor: one DUT output set per clock, compared against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc_out", pc_out, e.pc);
        check("imem_addr", imem_addr, e.pc);
        check("ifid_instr", ifid_instr, e.instr);
        check("ifid_pc_plus4", ifid_pc_plus4, e.pp4);
        check("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
        check("halted", {31'd0, halted}, {31'd0, e.halted});
        check("fetch_count", fetch_count, e.fc);
        check("stall_count", stall_count, e.sc);
      end
    end
  end

  task automatic reset_now_check();
    step(1, 1, 0, 32'h0);
    #1;
    check("async_rst_pc", pc_out, RST_PC);
    check("async_rst_instr", ifid_instr, 32'h0);
    check("async_rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("async_rst_halted", {31'd0, halted}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    m_pc = RST_PC; m_instr = 0; m_pp4 = 0; m_pend = 0;
    m_valid = 0; m_halted = 0; m_pend_flag = 0; m_boot = 1; m_fc = 0; m_sc = 0;

    reset_now_check();
    step(1, 0, 0, 0);
    // boot edge, then sequential fetch to pc=0x10
    repeat (5) step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    // redirect to misaligned 0x43
    step(0, 0, 1, 32'h43);
    repeat (3) step(0, 0, 0, 0);
    // redirect during stall, latest target wins
    step(0, 1, 1, 32'h20);
    step(0, 1, 1, 32'h80);
    step(0, 1, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    // run off the end of memory, stall in halt, restart from 0
    repeat (40) step(0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0);
    step(0, 0, 1, 32'h0);
    repeat (5) step(0, 0, 0, 0);
    // reset while a redirect is pending
    step(0, 1, 1, 32'h24);
    step(0, 1, 0, 32'h0);
    reset_now_check();
    repeat (6) step(0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      bit r, s, v;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 5) == 0);
      if (r) reset_now_check();
      else step(0, s, v, 32'($urandom_range(0, 300)));
    end

    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
